// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave frame engine: FSM states, command codes, frame sizing.
// Pure declarations; no logic, no latency, no flow control.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_TX      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int CMD_W = 2;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // A frame is the command field followed (or preceded, LSB-first) by the payload.
    function automatic int frame_w(input int payload_w);
        return payload_w + CMD_W;
    endfunction

endpackage

// File: rtl/spi_slave_frame_if.sv
// Controller-side bundle of spi_slave_frame: received frames and handshaked read data.
// Receive side is a one-cycle valid pulse with no backpressure; transmit side is ready/valid.
interface spi_slave_frame_if
    import spi_pkg::*;
#(
    parameter int PAYLOAD_W = 8
);
    localparam int FRAME_W = frame_w(PAYLOAD_W);

    logic [FRAME_W-1:0]   rx_data;
    logic                 rx_valid;
    logic [PAYLOAD_W-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 frame_err;
    logic                 busy;

    modport slave (
        output rx_data,
        output rx_valid,
        output tx_ready,
        output frame_err,
        output busy,
        input  tx_data,
        input  tx_valid
    );

    modport master (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        input  frame_err,
        input  busy,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/spi_slave_frame_shift_reg.sv
// Serial/parallel shift register; MSB_FIRST selects which end is the serial head/tail.
// Updates one cycle after load/shift_en, load wins over shift; no backpressure.
module spi_shift_reg #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         shift_en,
    input  logic         ser_in,
    output logic [W-1:0] par_out,
    output logic         ser_out
);

    logic [W-1:0] sreg_q;
    logic [W-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = load_dat;
        end else if (shift_en) begin
            // New bits enter at the far end from the head, so the first bit in ends up at the head side.
            if (MSB_FIRST) begin
                sreg_d = {sreg_q[W-2:0], ser_in};
            end else begin
                sreg_d = {ser_in, sreg_q[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign par_out = sreg_q;
    assign ser_out = MSB_FIRST ? sreg_q[W-1] : sreg_q[0];

endmodule

// File: rtl/spi_slave_frame.sv
// SPI slave frame engine: deserialises {cmd,payload} frames, serves read-data via ready/valid.
// rx_valid one cycle after the last bit; SS_n rising aborts with frame_err; tx_ready held until tx_valid.
module spi_slave_frame
    import spi_pkg::*;
#(
    parameter int PAYLOAD_W = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             MOSI,
    output wire              MISO,
    spi_slave_frame_if.slave ctl
);

    localparam int FRAME_W = frame_w(PAYLOAD_W);
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_TX_LAST = CNT_W'(PAYLOAD_W - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;

    logic                 rx_shift;
    logic                 tx_load;
    logic                 tx_shift;
    logic [FRAME_W-1:0]   rx_par;
    logic [1:0]           rx_cmd;
    logic                 tx_head;
    logic                 rx_ser_unused;
    logic [PAYLOAD_W-1:0] tx_par_unused;

    spi_shift_reg #(
        .W         (FRAME_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_rx_sreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_dat ('0),
        .shift_en (rx_shift),
        .ser_in   (MOSI),
        .par_out  (rx_par),
        .ser_out  (rx_ser_unused)
    );

    spi_shift_reg #(
        .W         (PAYLOAD_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx_sreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .load_dat (ctl.tx_data),
        .shift_en (tx_shift),
        .ser_in   (1'b0),
        .par_out  (tx_par_unused),
        .ser_out  (tx_head)
    );

    assign rx_cmd = rx_par[FRAME_W-1 -: 2];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_shift    = 1'b0;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!SS_n) begin
                    rx_shift = 1'b1;
                    cnt_d    = CNT_ONE;
                    state_d  = ST_RX;
                end
            end
            ST_RX: begin
                // All bits are already in, so a late SS_n rise no longer loses the frame.
                if (cnt_q == CNT_FULL) begin
                    rx_data_d  = rx_par;
                    rx_valid_d = 1'b1;
                    case (rx_cmd)
                        CMD_RD_DATA:                          state_d = ST_WAIT_TX;
                        CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR: state_d = ST_DONE;
                        default:                              state_d = ST_DONE;
                    endcase
                end else if (SS_n) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    rx_shift = 1'b1;
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_TX: begin
                if (SS_n) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (ctl.tx_valid && tx_ready_q) begin
                    tx_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (SS_n) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    tx_shift = 1'b1;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_TX_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (SS_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_ready_d = (state_d == ST_WAIT_TX);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign ctl.rx_data   = rx_data_q;
    assign ctl.rx_valid  = rx_valid_q;
    assign ctl.tx_ready  = tx_ready_q;
    assign ctl.frame_err = frame_err_q;
    assign ctl.busy      = busy_q;

    // The master may share MISO with other slaves, so release it whenever we are deselected.
    assign MISO = SS_n ? 1'bz : ((state_q == ST_TX) ? tx_head : 1'b0);

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame: an 8-bit MSB-first instance and a 16-bit LSB-first instance.
module tb_spi_slave_frame;

    logic clk = 1'b0;
    logic rst_n;
    logic ss_n;
    logic mosi;
    logic ss16_n;
    logic mosi16;
    wire  miso;
    wire  miso16;

    int checks = 0;
    int errors = 0;

    spi_slave_frame_if #(.PAYLOAD_W(8))  ctl8 ();
    spi_slave_frame_if #(.PAYLOAD_W(16)) ctl16 ();

    spi_slave_frame #(.PAYLOAD_W(8), .MSB_FIRST(1'b1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (ss_n),
        .MOSI  (mosi),
        .MISO  (miso),
        .ctl   (ctl8)
    );

    spi_slave_frame #(.PAYLOAD_W(16), .MSB_FIRST(1'b0)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (ss16_n),
        .MOSI  (mosi16),
        .MISO  (miso16),
        .ctl   (ctl16)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the first nbits of a 10-bit frame MSB first; returns just after the edge sampling the last one.
    task automatic send8(input logic [9:0] f, input int nbits);
        ss_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = f[9-i];
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; ss16_n = 1'b1; mosi16 = 1'b0;
        ctl8.tx_data = '0; ctl8.tx_valid = 1'b0; ctl16.tx_data = '0; ctl16.tx_valid = 1'b0;
        step(); step();
        checks++; if (ctl8.rx_data !== 10'h000) begin errors++; $display("FAIL rst_rx_data: got %h want 000", ctl8.rx_data); end
        checks++; if (ctl8.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", ctl8.rx_valid); end
        checks++; if (ctl8.tx_ready !== 1'b0) begin errors++; $display("FAIL rst_tx_ready: got %b want 0", ctl8.tx_ready); end
        checks++; if (ctl8.frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", ctl8.frame_err); end
        checks++; if (ctl8.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", ctl8.busy); end
        checks++; if (ctl16.rx_data !== 18'h00000) begin errors++; $display("FAIL rst_rx_data16: got %h want 00000", ctl16.rx_data); end
        ss_n = 1'b0;
        #1;
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso_sel: got %b want 0", miso); end
        ss_n = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (ctl8.busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after: got %b want 0", ctl8.busy); end
    endtask

    task automatic test_write_frame();
        logic [9:0] f;
        f = 10'h0A5;
        ss_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            mosi = f[9-k];
            step();
            checks++; if (ctl8.rx_valid !== 1'b0) begin errors++; $display("FAIL wr_valid_early cycle %0d: got %b want 0", k, ctl8.rx_valid); end
            checks++; if (miso !== 1'b0) begin errors++; $display("FAIL wr_miso_rx cycle %0d: got %b want 0", k, miso); end
        end
        step();
        checks++; if (ctl8.rx_valid !== 1'b1) begin errors++; $display("FAIL wr_valid_c10: got %b want 1", ctl8.rx_valid); end
        checks++; if (ctl8.rx_data !== 10'h0A5) begin errors++; $display("FAIL wr_rx_data: got %h want 0a5", ctl8.rx_data); end
        checks++; if (ctl8.tx_ready !== 1'b0) begin errors++; $display("FAIL wr_tx_ready_c10: got %b want 0", ctl8.tx_ready); end
        step();
        checks++; if (ctl8.rx_valid !== 1'b0) begin errors++; $display("FAIL wr_valid_c11: got %b want 0", ctl8.rx_valid); end
        checks++; if (ctl8.tx_ready !== 1'b0) begin errors++; $display("FAIL wr_tx_ready_c11: got %b want 0", ctl8.tx_ready); end
        checks++; if (ctl8.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_done: got %b want 1", ctl8.busy); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL wr_miso_done: got %b want 0", miso); end
        ss_n = 1'b1;
        step();
        checks++; if (ctl8.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_idle: got %b want 0", ctl8.busy); end
        checks++; if (ctl8.frame_err !== 1'b0) begin errors++; $display("FAIL wr_no_err: got %b want 0", ctl8.frame_err); end
    endtask

    task automatic test_read_data();
        logic [7:0] exp;
        exp = 8'h3C;
        send8(10'h300, 10);
        checks++; if (ctl8.tx_ready !== 1'b0) begin errors++; $display("FAIL rd_tx_ready_c9: got %b want 0", ctl8.tx_ready); end
        ctl8.tx_data = exp;
        step();
        checks++; if (ctl8.rx_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_c10: got %b want 1", ctl8.rx_valid); end
        checks++; if (ctl8.rx_data !== 10'h300) begin errors++; $display("FAIL rd_rx_data: got %h want 300", ctl8.rx_data); end
        for (int c = 10; c <= 12; c++) begin
            checks++; if (ctl8.tx_ready !== 1'b1) begin errors++; $display("FAIL rd_tx_ready cycle %0d: got %b want 1", c, ctl8.tx_ready); end
            if (c == 12) ctl8.tx_valid = 1'b1;
            step();
        end
        ctl8.tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (miso !== exp[7-i]) begin errors++; $display("FAIL rd_miso cycle %0d: got %b want %b", 13 + i, miso, exp[7-i]); end
            if (i == 0) begin
                checks++; if (ctl8.tx_ready !== 1'b0) begin errors++; $display("FAIL rd_tx_ready_c13: got %b want 0", ctl8.tx_ready); end
            end
            step();
        end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rd_miso_done: got %b want 0", miso); end
        checks++; if (ctl8.busy !== 1'b1) begin errors++; $display("FAIL rd_busy_done: got %b want 1", ctl8.busy); end
        ctl8.tx_valid = 1'b1;
        step();
        ctl8.tx_valid = 1'b0;
        checks++; if (ctl8.tx_ready !== 1'b0) begin errors++; $display("FAIL rd_tx_valid_ignored: got %b want 0", ctl8.tx_ready); end
        ss_n = 1'b1;
        step();
        checks++; if (ctl8.busy !== 1'b0) begin errors++; $display("FAIL rd_busy_idle: got %b want 0", ctl8.busy); end
        checks++; if (ctl8.frame_err !== 1'b0) begin errors++; $display("FAIL rd_no_err: got %b want 0", ctl8.frame_err); end
    endtask

    task automatic test_back_to_back();
        send8(10'h1C3, 10);
        step();
        checks++; if (ctl8.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b want 1", ctl8.rx_valid); end
        checks++; if (ctl8.rx_data !== 10'h1C3) begin errors++; $display("FAIL b2b_data1: got %h want 1c3", ctl8.rx_data); end
        ss_n = 1'b1;
        step();
        checks++; if (ctl8.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %b want 0", ctl8.busy); end
        send8(10'h03C, 10);
        checks++; if (ctl8.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid2_early: got %b want 0", ctl8.rx_valid); end
        step();
        checks++; if (ctl8.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b want 1", ctl8.rx_valid); end
        checks++; if (ctl8.rx_data !== 10'h03C) begin errors++; $display("FAIL b2b_data2: got %h want 03c", ctl8.rx_data); end
        ss_n = 1'b1;
        step();
    endtask

    task automatic test_abort();
        send8(10'h1FF, 5);
        ss_n = 1'b1;
        step();
        checks++; if (ctl8.frame_err !== 1'b1) begin errors++; $display("FAIL ab_err: got %b want 1", ctl8.frame_err); end
        checks++; if (ctl8.rx_valid !== 1'b0) begin errors++; $display("FAIL ab_valid: got %b want 0", ctl8.rx_valid); end
        checks++; if (ctl8.busy !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b want 0", ctl8.busy); end
        checks++; if (ctl8.rx_data !== 10'h03C) begin errors++; $display("FAIL ab_data_kept: got %h want 03c", ctl8.rx_data); end
        step();
        checks++; if (ctl8.frame_err !== 1'b0) begin errors++; $display("FAIL ab_err_pulse: got %b want 0", ctl8.frame_err); end
        checks++; if (ctl8.rx_valid !== 1'b0) begin errors++; $display("FAIL ab_valid_late: got %b want 0", ctl8.rx_valid); end
    endtask

    task automatic test_simultaneous_edge();
        send8(10'h0F0, 9);
        ss_n = 1'b1;
        step();
        checks++; if (ctl8.frame_err !== 1'b1) begin errors++; $display("FAIL sim_err: got %b want 1", ctl8.frame_err); end
        checks++; if (ctl8.rx_valid !== 1'b0) begin errors++; $display("FAIL sim_valid: got %b want 0", ctl8.rx_valid); end
        step();
        checks++; if (ctl8.frame_err !== 1'b0) begin errors++; $display("FAIL sim_err_pulse: got %b want 0", ctl8.frame_err); end
        checks++; if (ctl8.rx_valid !== 1'b0) begin errors++; $display("FAIL sim_valid_late: got %b want 0", ctl8.rx_valid); end
        checks++; if (ctl8.rx_data !== 10'h03C) begin errors++; $display("FAIL sim_data_kept: got %h want 03c", ctl8.rx_data); end
        checks++; if (ctl8.busy !== 1'b0) begin errors++; $display("FAIL sim_busy: got %b want 0", ctl8.busy); end
    endtask

    task automatic test_abort_wait_tx();
        send8(10'h3AA, 10);
        step();
        checks++; if (ctl8.tx_ready !== 1'b1) begin errors++; $display("FAIL abw_tx_ready: got %b want 1", ctl8.tx_ready); end
        ss_n = 1'b1;
        step();
        checks++; if (ctl8.frame_err !== 1'b1) begin errors++; $display("FAIL abw_err: got %b want 1", ctl8.frame_err); end
        checks++; if (ctl8.tx_ready !== 1'b0) begin errors++; $display("FAIL abw_tx_ready_off: got %b want 0", ctl8.tx_ready); end
        checks++; if (ctl8.rx_data !== 10'h3AA) begin errors++; $display("FAIL abw_data: got %h want 3aa", ctl8.rx_data); end
        step();
    endtask

    task automatic test_reset_mid_tx();
        send8(10'h300, 10);
        ctl8.tx_data  = 8'h1F;
        ctl8.tx_valid = 1'b1;
        step();
        step();
        ctl8.tx_valid = 1'b0;
        step();
        step();
        step();
        checks++; if (miso !== 1'b1) begin errors++; $display("FAIL rtx_miso_bit4: got %b want 1", miso); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ctl8.busy !== 1'b0) begin errors++; $display("FAIL rtx_busy: got %b want 0", ctl8.busy); end
        checks++; if (ctl8.rx_data !== 10'h000) begin errors++; $display("FAIL rtx_rx_data: got %h want 000", ctl8.rx_data); end
        checks++; if (ctl8.tx_ready !== 1'b0) begin errors++; $display("FAIL rtx_tx_ready: got %b want 0", ctl8.tx_ready); end
        checks++; if (ctl8.frame_err !== 1'b0) begin errors++; $display("FAIL rtx_err: got %b want 0", ctl8.frame_err); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rtx_miso: got %b want 0", miso); end
        step();
        rst_n = 1'b1;
        ss_n  = 1'b1;
        step();
        checks++; if (ctl8.frame_err !== 1'b0) begin errors++; $display("FAIL rtx_no_err: got %b want 0", ctl8.frame_err); end
        send8(10'h15A, 10);
        step();
        checks++; if (ctl8.rx_valid !== 1'b1) begin errors++; $display("FAIL rtx_next_valid: got %b want 1", ctl8.rx_valid); end
        checks++; if (ctl8.rx_data !== 10'h15A) begin errors++; $display("FAIL rtx_next_data: got %h want 15a", ctl8.rx_data); end
        ss_n = 1'b1;
        step();
    endtask

    task automatic test_lsb16();
        logic [17:0] f;
        f = 18'h12345;
        ss16_n = 1'b0;
        for (int i = 0; i < 18; i++) begin
            mosi16 = f[i];
            step();
        end
        checks++; if (ctl16.rx_valid !== 1'b0) begin errors++; $display("FAIL lsb_valid_early: got %b want 0", ctl16.rx_valid); end
        step();
        checks++; if (ctl16.rx_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %b want 1", ctl16.rx_valid); end
        checks++; if (ctl16.rx_data !== 18'h12345) begin errors++; $display("FAIL lsb_data: got %h want 12345", ctl16.rx_data); end
        checks++; if (ctl16.rx_data[17:16] !== 2'b01) begin errors++; $display("FAIL lsb_cmd: got %b want 01", ctl16.rx_data[17:16]); end
        checks++; if (ctl16.tx_ready !== 1'b0) begin errors++; $display("FAIL lsb_tx_ready: got %b want 0", ctl16.tx_ready); end
        ss16_n = 1'b1;
        step();
        step();
        checks++; if (ctl16.busy !== 1'b0) begin errors++; $display("FAIL lsb_busy: got %b want 0", ctl16.busy); end
    endtask

    task automatic test_lsb16_tx();
        logic [17:0] f;
        logic [15:0] exp;
        f   = 18'h30000;
        exp = 16'hA00D;
        ss16_n = 1'b0;
        for (int i = 0; i < 18; i++) begin
            mosi16 = f[i];
            step();
        end
        ctl16.tx_data = exp;
        step();
        checks++; if (ctl16.tx_ready !== 1'b1) begin errors++; $display("FAIL lsbtx_ready: got %b want 1", ctl16.tx_ready); end
        ctl16.tx_valid = 1'b1;
        step();
        ctl16.tx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (miso16 !== exp[i]) begin errors++; $display("FAIL lsbtx_miso bit %0d: got %b want %b", i, miso16, exp[i]); end
            step();
        end
        checks++; if (miso16 !== 1'b0) begin errors++; $display("FAIL lsbtx_miso_done: got %b want 0", miso16); end
        ss16_n = 1'b1;
        step();
        checks++; if (ctl16.busy !== 1'b0) begin errors++; $display("FAIL lsbtx_busy: got %b want 0", ctl16.busy); end
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_read_data();
        test_back_to_back();
        test_abort();
        test_simultaneous_edge();
        test_abort_wait_tx();
        test_reset_mid_tx();
        test_lsb16();
        test_lsb16_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
